// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Encodes MIPS-style instruction fields into 32-bit machine words, buffers
// them in a small FIFO and streams them into an instruction memory at
// consecutive word addresses starting from 0. When the last address has been
// written, the block parks in DONE until clear or reset.
//
// Ports
//   clk                        single clock, rising edge
//   reset                      asynchronous, active-high
//   in_valid / in_ready        instruction-field handshake
//   in_mnem                    0 add,1 sub,2 and,3 or,4 slt,5 sll,6 srl,
//                              7 lw,8 sw,9 lh,10 sh,11 addi,12 beq
//   in_rs/in_rt/in_rd/in_shamt register and shift-amount fields
//   in_imm                     immediate / offset
//   clear                      synchronous restart (flush, address 0)
//   imem_we/imem_addr/imem_wdata  instruction-memory write port (registered)
//   done                       memory image full
//   err                        sticky illegal-mnemonic flag
//
// Build option
//   HALFWORD_EN  defined: lh/sh are encoded; undefined: mnemonics 9/10 illegal.
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic              clear,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Encoding helpers
    // -----------------------------------------------------------------------
    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {6'h00, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Returns {legal, word}; an illegal mnemonic yields legal=0.
    function automatic logic [32:0] encode(input logic [3:0]  mnem,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rd,
                                           input logic [4:0]  shamt,
                                           input logic [15:0] imm);
        logic [32:0] r;
        r = '0;
        case (mnem)
            // Non-shift R-types carry no shift amount; shifts carry no rs.
            4'd0:  r = {1'b1, rtype(rs,    rt, rd, 5'd0,  6'h20)};
            4'd1:  r = {1'b1, rtype(rs,    rt, rd, 5'd0,  6'h22)};
            4'd2:  r = {1'b1, rtype(rs,    rt, rd, 5'd0,  6'h24)};
            4'd3:  r = {1'b1, rtype(rs,    rt, rd, 5'd0,  6'h25)};
            4'd4:  r = {1'b1, rtype(rs,    rt, rd, 5'd0,  6'h2A)};
            4'd5:  r = {1'b1, rtype(5'd0,  rt, rd, shamt, 6'h00)};
            4'd6:  r = {1'b1, rtype(5'd0,  rt, rd, shamt, 6'h02)};
            4'd7:  r = {1'b1, itype(6'h23, rs, rt, imm)};
            4'd8:  r = {1'b1, itype(6'h2B, rs, rt, imm)};
`ifdef HALFWORD_EN
            4'd9:  r = {1'b1, itype(6'h21, rs, rt, imm)};
            4'd10: r = {1'b1, itype(6'h29, rs, rt, imm)};
`endif
            4'd11: r = {1'b1, itype(6'h08, rs, rt, imm)};
            4'd12: r = {1'b1, itype(6'h04, rs, rt, imm)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Stage p0: combinational encode of the presented fields
    // -----------------------------------------------------------------------
    logic [32:0] enc_p0;
    logic        legal_p0;
    logic [31:0] word_p0;

    assign enc_p0   = encode(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm);
    assign legal_p0 = enc_p0[32];
    assign word_p0  = enc_p0[31:0];

    // FIFO storage and control state
    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [PTR_W:0]    count, cnt_nxt;
    logic [ADDR_W-1:0] addr;
    state_t            state, state_nxt;

    logic hs, push, last_wr, can_issue, pop, bypass, issue, fifo_wr;
    logic [31:0] out_word;

    assign in_ready = !reset && (count != FULL_CNT) && (state != S_DONE) && !clear;
    assign done     = (state == S_DONE);

    always_comb begin
        hs        = in_valid && in_ready;
        push      = hs && legal_p0;
        // The write to the last address is on the port this cycle: no more
        // words may be issued, the FSM parks in DONE at the next edge.
        last_wr   = imem_we && (imem_addr == ADDR_LAST);
        can_issue = (state != S_DONE) && !last_wr;
        pop       = can_issue && (count != '0);
        // With an empty FIFO the accepted word goes straight to the write
        // register so it appears on the memory port one cycle after acceptance.
        bypass    = can_issue && (count == '0) && push;
        issue     = pop || bypass;
        fifo_wr   = push && !bypass;
        out_word  = pop ? mem[rptr] : word_p0;
        cnt_nxt   = count + {{PTR_W{1'b0}}, fifo_wr} - {{PTR_W{1'b0}}, pop};
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_DONE:  state_nxt = S_DONE;
                default: begin
                    if (last_wr)
                        state_nxt = S_DONE;
                    else if (cnt_nxt != '0)
                        state_nxt = S_WRITE;
                    else
                        state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FIFO storage carries data only; pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (fifo_wr && !clear)
            mem[wptr] <= word_p0;
    end

    // -----------------------------------------------------------------------
    // Stage p1: FIFO pointers, address counter and registered write port
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            addr       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
        end else if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            addr      <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            err       <= 1'b0;
        end else begin
            count <= cnt_nxt;
            if (fifo_wr)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (hs && !legal_p0)
                err <= 1'b1;
            imem_we <= issue;
            if (issue) begin
                imem_addr  <= addr;
                imem_wdata <= out_word;
                // Hold at the last address; DONE prevents any further issue.
                if (addr != ADDR_LAST)
                    addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main instance, default parameters
    logic        in_valid, in_ready, clear, imem_we, done, err;
    logic [3:0]  in_mnem;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;

    // Small instance with a 4-word memory image
    logic        s_valid, s_ready, s_clear, s_we, s_done, s_err;
    logic [3:0]  s_mnem;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
    logic [15:0] s_imm;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;

    instr_encoder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm),
        .clear(clear),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .done(done), .err(err)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut_s (
        .clk(clk), .reset(reset),
        .in_valid(s_valid), .in_ready(s_ready),
        .in_mnem(s_mnem), .in_rs(s_rs), .in_rt(s_rt), .in_rd(s_rd),
        .in_shamt(s_shamt), .in_imm(s_imm),
        .clear(s_clear),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .done(s_done), .err(s_err)
    );

    typedef struct {
        logic [3:0]  mnem;
        logic [4:0]  rs, rt, rd, shamt;
        logic [15:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] word;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    exp_t        mon_e;
    logic [33:0] s_log[$];
    logic [7:0]  nxt_addr;
    logic        err_exp;
    int          nvec = 0;
    int          nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                                input logic lg, input logic [31:0] w);
        vec_t v;
        v.mnem = m; v.rs = rs; v.rt = rt; v.rd = rd; v.shamt = sh; v.imm = imm;
        v.legal = lg; v.word = w;
        return v;
    endfunction

    // Scoreboard check of every write on the main instance
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            if (sb.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL unexpected_write: addr %0d data %h, no write expected", imem_addr, imem_wdata);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", {24'd0, imem_addr}, {24'd0, mon_e.addr});
                chk("wr_data", imem_wdata, mon_e.word);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && s_we)
            s_log.push_back({s_addr, s_wdata});
    end

    task automatic send(input vec_t v);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_mnem = v.mnem; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
        in_shamt = v.shamt; in_imm = v.imm;
        k = 0;
        while (!in_ready && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            nvec++;
            nmis++;
            $display("FAIL send_timeout: in_ready 0 after 64 cycles, expected 1");
            in_valid = 1'b0;
        end else begin
            if (v.legal) begin
                sb.push_back({nxt_addr, v.word});
                nxt_addr++;
            end
            err_exp = err_exp | !v.legal;
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; in_mnem = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_shamt = 0; in_imm = 0; clear = 0;
        s_valid = 0; s_mnem = 4'd0; s_rs = 5'd1; s_rt = 5'd2; s_rd = 0; s_shamt = 0; s_imm = 0; s_clear = 0;
        nxt_addr = 0;
        err_exp = 1'b0;

        tbl.push_back(mk(4'd0,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 1'b1, 32'h00221820));
        tbl.push_back(mk(4'd7,  5'd29, 5'd8,  5'd0,  5'd0,  16'h0004, 1'b1, 32'h8FA80004));
        tbl.push_back(mk(4'd5,  5'd5,  5'd9,  5'd10, 5'd2,  16'h0000, 1'b1, 32'h00095080));
        tbl.push_back(mk(4'd1,  5'd4,  5'd5,  5'd6,  5'd7,  16'h0000, 1'b1, 32'h00853022));
        tbl.push_back(mk(4'd2,  5'd7,  5'd8,  5'd9,  5'd0,  16'h0000, 1'b1, 32'h00E84824));
        tbl.push_back(mk(4'd3,  5'd31, 5'd31, 5'd31, 5'd31, 16'h0000, 1'b1, 32'h03FFF825));
        tbl.push_back(mk(4'd4,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 1'b1, 32'h0022182A));
        tbl.push_back(mk(4'd6,  5'd0,  5'd3,  5'd4,  5'd31, 16'h0000, 1'b1, 32'h000327C2));
        tbl.push_back(mk(4'd8,  5'd29, 5'd31, 5'd0,  5'd0,  16'hFFFC, 1'b1, 32'hAFBFFFFC));
        tbl.push_back(mk(4'd11, 5'd0,  5'd1,  5'd0,  5'd0,  16'h0005, 1'b1, 32'h20010005));
        tbl.push_back(mk(4'd12, 5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFF, 1'b1, 32'h1022FFFF));
`ifdef HALFWORD_EN
        tbl.push_back(mk(4'd9,  5'd2,  5'd3,  5'd0,  5'd0,  16'h0006, 1'b1, 32'h84430006));
        tbl.push_back(mk(4'd10, 5'd2,  5'd3,  5'd0,  5'd0,  16'h0006, 1'b1, 32'hA4430006));
`else
        tbl.push_back(mk(4'd9,  5'd2,  5'd3,  5'd0,  5'd0,  16'h0006, 1'b0, 32'h0));
        tbl.push_back(mk(4'd10, 5'd2,  5'd3,  5'd0,  5'd0,  16'h0006, 1'b0, 32'h0));
`endif
        tbl.push_back(mk(4'd14, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 1'b0, 32'h0));
        tbl.push_back(mk(4'd0,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 1'b1, 32'h00221820));
        tbl.push_back(mk(4'd13, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 32'h0));
        tbl.push_back(mk(4'd15, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 32'h0));

        // Reset values
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we",    {31'd0, imem_we},  32'd0);
        chk("rst_addr",  {24'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_err",   {31'd0, err},  32'd0);
        in_valid = 1'b0;
        reset = 1'b0;

        // First-word latency: add accepted at edge N, written in cycle N+1
        send(tbl[0]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_we", {31'd0, imem_we}, 32'd1);

        // Table stream, back to back
        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i]);
            #1;
            chk($sformatf("err_v%0d", i), {31'd0, err}, {31'd0, err_exp});
        end
        idle();
        repeat (3) @(negedge clk);
        chk("drain", sb.size(), 32'd0);

        // clear has priority over a presented handshake
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_mnem = 4'd0;
        #1;
        chk("clr_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_we",  {31'd0, imem_we}, 32'd0);
        chk("clr_err", {31'd0, err}, 32'd0);
        nxt_addr = 0;
        err_exp = 1'b0;

        // Illegal then addi: err set, addi lands at address 0
        send(mk(4'd14, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 1'b0, 32'h0));
        idle();
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_we",  {31'd0, imem_we}, 32'd0);
        send(mk(4'd11, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0005, 1'b1, 32'h20010005));
        idle();
        repeat (2) @(negedge clk);
        chk("ill_drain", sb.size(), 32'd0);

        // Reset in the middle of a stream
        send(tbl[0]);
        send(tbl[1]);
        send(tbl[3]);
        #2 reset = 1'b1;
        #1;
        sb.delete();
        chk("mrst_we",    {31'd0, imem_we}, 32'd0);
        chk("mrst_addr",  {24'd0, imem_addr}, 32'd0);
        chk("mrst_wdata", imem_wdata, 32'd0);
        chk("mrst_done",  {31'd0, done}, 32'd0);
        chk("mrst_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("mrst_hold_we", {31'd0, imem_we}, 32'd0);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        nxt_addr = 0;
        repeat (3) @(negedge clk);
        chk("mrst_after_we", {31'd0, imem_we}, 32'd0);

        // Small instance: fill the 4-word image, fifth word stays queued
        s_log.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_rd = 5'(k);
            chk($sformatf("s_ready%0d", k), {31'd0, s_ready}, 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        chk("s_done",     {31'd0, s_done}, 32'd1);
        chk("s_ready_dn", {31'd0, s_ready}, 32'd0);
        chk("s_we_dn",    {31'd0, s_we}, 32'd0);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("s_done_hold", {31'd0, s_done}, 32'd1);
        chk("s_nwrites", s_log.size(), 32'd4);
        for (int k = 0; k < 4 && k < s_log.size(); k++) begin
            chk($sformatf("s_addr%0d", k), {30'd0, s_log[k][33:32]}, 32'(k));
            chk($sformatf("s_data%0d", k), s_log[k][31:0], 32'h00220020 | (32'(k) << 11));
        end
        s_clear = 1'b1;
        @(negedge clk);
        s_clear = 1'b0;
        chk("s_clr_done", {31'd0, s_done}, 32'd0);
        s_log.delete();
        @(negedge clk);
        s_valid = 1'b1;
        s_rd = 5'd9;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        chk("s_post_we",   {31'd0, s_we}, 32'd1);
        chk("s_post_addr", {30'd0, s_addr}, 32'd0);
        chk("s_post_data", s_wdata, 32'h00224820);
        repeat (3) @(negedge clk);
        chk("s_post_n", s_log.size(), 32'd1);
        chk("s_err", {31'd0, s_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, default 4, encoded-word FIFO entries (power of 2, >=2).
REQ-002 Parameter: ADDR_W, default 8, instruction-memory word-address width.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid / in_ready  input / output  1 / 1  instruction-field handshake; transfer when both high on an edge.
REQ-006 Port: in_mnem  input  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll, 6 srl, 7 lw, 8 sw, 9 lh, 10 sh, 11 addi, 12 beq; 13-15 illegal.
REQ-007 Port: in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift-amount fields.
REQ-008 Port: in_imm  input  16  immediate or offset.
REQ-009 Port: clear  input  1  synchronous restart: flush FIFO, zero address, leave DONE.
REQ-010 Port: imem_we / imem_addr / imem_wdata  output  1 / ADDR_W / 32  instruction-memory write port.
REQ-011 Port: done / err  output  1 / 1  memory image full / sticky illegal-mnemonic flag.

Function
REQ-012 Encoding: R-type {6'h00, rs, rt, rd, shamt, funct}; add 20, sub 22, and 24, or 25, slt 2A, sll 00, srl 02 (hex).
REQ-013 sll/srl: rs field forced to 0; non-shift R-types: shamt field forced to 0.
REQ-014 I-type {op, rs, rt, imm}; op lw 23, sw 2B, lh 21, sh 29, addi 08, beq 04 (hex).
REQ-015 Encoding is combinational on input fields; the word enters the FIFO on the accepting edge.
REQ-016 in_ready = FIFO not full AND state != DONE AND clear low.
REQ-017 Illegal mnemonic: handshake completes, nothing enqueued, err set; err held until reset or clear.
REQ-018 FSM states IDLE (FIFO empty), WRITE (FIFO non-empty), DONE (last address written).
REQ-019 In WRITE: one FIFO word popped per cycle; registered imem_we=1, imem_wdata=word, imem_addr=current address.
REQ-020 Latency: word accepted at edge N appears with imem_we high in cycle N+1 when FIFO was empty.
REQ-021 Address increments by 1 after each write; the write at address 2^ADDR_W-1 sends FSM to DONE; no wrap.
REQ-022 DONE: done=1, imem_we=0, in_ready=0, remaining FIFO contents held; exit only via clear or reset.
REQ-023 Simultaneous push and pop with FIFO full: pop takes effect, push refused (in_ready already 0); with FIFO non-full both occur and count is unchanged.
REQ-024 clear has priority over handshake and write in the same cycle; no imem_we in the following cycle.
REQ-025 Words are written in acceptance order, no drops or duplicates.

Reset
REQ-026 On reset: state IDLE, FIFO empty, address 0, imem_we 0, imem_addr 0, imem_wdata 0, done 0, err 0, in_ready 0 while reset high.
REQ-027 Reset asserted mid-operation discards FIFO contents; an in-flight write is not completed.

Configuration
REQ-028 Macro HALFWORD_EN: defined -> lh/sh encoded per REQ-014; undefined -> mnemonics 9 and 10 illegal per REQ-017.

Verification
REQ-029 add rs=1 rt=2 rd=3 after reset -> next cycle imem_we=1, addr 0, wdata 0x00221820.
REQ-030 lw rs=29 rt=8 imm=0x0004 then sll rt=9 rd=10 shamt=2 -> wdata 0x8FA80004 at addr 0, 0x00095080 at addr 1.
REQ-031 mnem 14 -> err=1, no imem_we, address stays 0; following addi rs=0 rt=1 imm=5 -> 0x20010005 at addr 0.
REQ-032 ADDR_W=2, 5 back-to-back adds -> writes to addrs 0..3, done=1, in_ready=0, 5th word held; clear -> done=0, address 0, FIFO empty.
REQ-033 HALFWORD_EN undefined, lh -> err=1, nothing written; defined, lh rs=2 rt=3 imm=6 -> 0x84430006.
REQ-034 reset pulse with 3 words queued -> no further imem_we, all outputs at reset values.
